hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised register-hazard interlock between decode and execute, the successor to the single-load interlock. Tracks every architectural register with a pending result in a per-register countdown (fixed-latency producers: load, multi-stage multiply) plus a busy flag (variable-latency producers: divider, CSR/cache ops). Asserts a stall for the decode-stage instruction while any enabled source register is not yet forwardable. Keeps a saturating stall-cycle performance counter.

## Interface
Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- NSRC, 2, source operands checked per decode instruction.
- MAXLAT, 7, largest fixed latency accepted on iss_lat.
- RA_W, $clog2(NREG), register index width (derived).
- LAT_W, $clog2(MAXLAT+1), countdown width (derived).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- ds_valid  in  1  decode stage holds a valid instruction.
- ds_src_en  in  NSRC  per-source read enable.
- ds_src_addr  in  NSRC*RA_W  source indices, source i at bits [i*RA_W +: RA_W].
- iss_valid  in  1  an instruction leaves decode this cycle; upstream asserts it only when stall is low.
- iss_dest  in  RA_W  destination of issuing instruction.
- iss_lat  in  LAT_W  cycles a dependent must stall after issue (ALU 0, load 1, 3-stage mul 3).
- iss_var  in  1  variable-latency producer; busy until var_done.
- var_done  in  1  variable-latency result now forwardable.
- var_dest  in  RA_W  register completed by var_done.
- flush  in  1  pipeline flush (exception/ertn/branch redirect).
- stall  out  1  decode must hold.
- stall_src  out  NSRC  one-hot-per-source hazard flags.
- stall_cycles  out  32  saturating count of cycles with stall high.

## Operation
- Per register r in 1..NREG-1: cnt[r] (LAT_W bits), busy[r] (1 bit). Register 0 has no state; reads of 0 never hazard.
- Update priority per register, highest first:
  - flush: cnt[r]<=0, busy[r]<=0.
  - issue (iss_valid, iss_dest==r, r!=0): cnt[r]<=iss_lat; busy[r]<=iss_var. Overwrites any older pending entry (WAW: newer producer governs).
  - var_done with var_dest==r: busy[r]<=0; cnt unaffected.
  - otherwise cnt[r]<=cnt[r]-1 if nonzero (no wrap below 0).
- Issue and var_done to the same r in one cycle: issue wins, busy[r]=iss_var.
- Issue with iss_dest==0 ignored. iss_lat>MAXLAT cannot occur by width.
- stall_src[i] = ds_valid & ds_src_en[i] & addr_i!=0 & (cnt[addr_i]!=0 | busy[addr_i]).
- stall = OR of stall_src.
- stall_cycles increments each cycle stall is high; holds at 32'hFFFF_FFFF; cleared only by reset (not flush).

## Timing
- Reset values: all cnt=0, busy=0, stall=0, stall_src=0, stall_cycles=0; reset asynchronous, mid-countdown entries discarded immediately.
- stall/stall_src are combinational from registered state and ds_* inputs only; no combinational path from iss_*, var_*, or flush to stall.
- Issue in cycle T is visible from T+1: a dependent entering decode at T+1 stalls exactly iss_lat cycles (T+1..T+iss_lat), released at T+iss_lat+1.
- Load then immediate dependent: exactly 1 stall cycle.
- var_done at T releases the dependent at T+1.
- Flush at T: stall low from T+1 (regardless of pending entries).

## Structure
- Shared header mycpu.vh: DS_TO_SB_BUS_WD, ES_TO_SB_BUS_WD and latency constants LAT_ALU=0, LAT_LOAD=1, LAT_MUL=3.
- One sub-module: sb_entry (cnt + busy, update priority above), instantiated by generate for r=1..NREG-1; top holds source mux, OR reduction and perf counter.

## Test plan
- Load-use: issue r5 lat 1, next cycle ds reads r5 -> stall high 1 cycle, stall_src=2'b01, stall_cycles=1.
- Register 0: issue r0 lat 3, ds reads r0 on both sources -> stall never asserts.
- Multiply: issue r7 lat 3, dependent on source 1 -> stall 3 cycles, stall_src=2'b10, released 4th cycle.
- Divider: issue r9 iss_var=1 lat 0, hold dependent 20 cycles, var_done r9 -> stall drops next cycle; stall_cycles=20.
- WAW/simultaneous: r4 busy (var), same cycle var_done r4 and new issue r4 lat 1 -> busy stays 0, cnt=1, one stall cycle.
- Flush/reset: issue r3 lat 5, flush after 2 cycles -> stall low next cycle; repeat with reset asserted mid-countdown -> all outputs 0 immediately, stall_cycles=0.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the register-hazard scoreboard.
//   - Producer latency constants (ALU, load, multiply) used by issue logic.
//   - Bus widths of the decode->scoreboard and execute->scoreboard bundles
//     for the default configuration (NREG=32, NSRC=2, MAXLAT=7).
//   - Saturating 32-bit increment used by the stall performance counter.
package hazard_scoreboard_pkg;

    localparam int LAT_ALU  = 0;
    localparam int LAT_LOAD = 1;
    localparam int LAT_MUL  = 3;

    // ds_valid + NSRC enables + NSRC 5-bit indices
    localparam int DS_TO_SB_BUS_WD = 1 + 2 + 2 * 5;
    // iss_valid + dest + 3-bit latency + iss_var
    localparam int ES_TO_SB_BUS_WD = 1 + 5 + 3 + 1;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/hazard_scoreboard_sb_entry.sv
// Per-register pending-result state for register IDX.
//   cnt  : countdown of cycles until a fixed-latency result is forwardable.
//   busy : a variable-latency producer owns the register until var_done.
// Ports:
//   clk, reset          clock, async active-high reset
//   flush               discard pending state
//   iss_valid/dest/lat/var  issuing producer
//   var_done/var_dest   variable-latency completion
//   pending             register is not yet forwardable (cnt!=0 | busy)
module sb_entry
    import hazard_scoreboard_pkg::*;
#(
    parameter int RA_W  = 5,
    parameter int LAT_W = 3,
    parameter int IDX   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             iss_valid,
    input  logic [RA_W-1:0]  iss_dest,
    input  logic [LAT_W-1:0] iss_lat,
    input  logic             iss_var,
    input  logic             var_done,
    input  logic [RA_W-1:0]  var_dest,
    output logic             pending
);

    localparam logic [RA_W-1:0] MY_ADDR = RA_W'(IDX);

    logic [LAT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    wire iss_hit = iss_valid && (iss_dest == MY_ADDR);
    wire var_hit = var_done && (var_dest == MY_ADDR);

    // Flush beats issue beats completion beats countdown. A new issue
    // overwrites any older producer, so the newest writer governs (WAW).
    always_comb begin
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (flush) begin
            cnt_d  = '0;
            busy_d = 1'b0;
        end else if (iss_hit) begin
            cnt_d  = iss_lat;
            busy_d = iss_var;
        end else if (var_hit) begin
            busy_d = 1'b0;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign pending = (cnt_q != '0) || busy_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-hazard interlock between decode and execute.
// Holds one sb_entry per architectural register (r0 has none: it never
// hazards), selects the pending flag for each decode source, and counts
// stall cycles in a saturating 32-bit counter cleared only by reset.
// Ports:
//   clk, reset                  clock, async active-high reset
//   ds_valid/ds_src_en/ds_src_addr  decode-stage sources (source i at
//                               ds_src_addr[i*RA_W +: RA_W])
//   iss_valid/iss_dest/iss_lat/iss_var  instruction leaving decode
//   var_done/var_dest           variable-latency completion
//   flush                       pipeline flush
//   stall, stall_src            decode hold, per-source hazard flags
//   stall_cycles                saturating stall-cycle count
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int NSRC   = 2,
    parameter int MAXLAT = 7,
    parameter int RA_W   = $clog2(NREG),
    parameter int LAT_W  = $clog2(MAXLAT + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ds_valid,
    input  logic [NSRC-1:0]      ds_src_en,
    input  logic [NSRC*RA_W-1:0] ds_src_addr,
    input  logic                 iss_valid,
    input  logic [RA_W-1:0]      iss_dest,
    input  logic [LAT_W-1:0]     iss_lat,
    input  logic                 iss_var,
    input  logic                 var_done,
    input  logic [RA_W-1:0]      var_dest,
    input  logic                 flush,
    output logic                 stall,
    output logic [NSRC-1:0]      stall_src,
    output logic [31:0]          stall_cycles
);

    logic [NREG-1:0] pend;
    logic [31:0]     stall_cycles_q, stall_cycles_d;

    assign pend[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_ent
        sb_entry #(
            .RA_W  (RA_W),
            .LAT_W (LAT_W),
            .IDX   (r)
        ) u_ent (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .iss_valid (iss_valid),
            .iss_dest  (iss_dest),
            .iss_lat   (iss_lat),
            .iss_var   (iss_var),
            .var_done  (var_done),
            .var_dest  (var_dest),
            .pending   (pend[r])
        );
    end

    // Stall depends only on registered entry state and ds_* inputs, so the
    // issue/flush/completion signals of this cycle never reach stall.
    for (genvar i = 0; i < NSRC; i++) begin : g_src
        wire [RA_W-1:0] addr = ds_src_addr[i*RA_W +: RA_W];
        assign stall_src[i] = ds_valid && ds_src_en[i] && pend[addr];
    end

    assign stall = |stall_src;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall) stall_cycles_d = sat_inc32(stall_cycles_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cycles_q <= '0;
        else       stall_cycles_q <= stall_cycles_d;
    end

    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    localparam int NREG = 32, NSRC = 2, MAXLAT = 7, RA_W = 5, LAT_W = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 ds_valid;
    logic [NSRC-1:0]      ds_src_en;
    logic [NSRC*RA_W-1:0] ds_src_addr;
    logic                 iss_valid;
    logic [RA_W-1:0]      iss_dest;
    logic [LAT_W-1:0]     iss_lat;
    logic                 iss_var;
    logic                 var_done;
    logic [RA_W-1:0]      var_dest;
    logic                 flush;
    logic                 stall;
    logic [NSRC-1:0]      stall_src;
    logic [31:0]          stall_cycles;

    int errors = 0;
    int checks = 0;

    hazard_scoreboard #(.NREG(NREG), .NSRC(NSRC), .MAXLAT(MAXLAT)) dut (
        .clk          (clk),
        .reset        (reset),
        .ds_valid     (ds_valid),
        .ds_src_en    (ds_src_en),
        .ds_src_addr  (ds_src_addr),
        .iss_valid    (iss_valid),
        .iss_dest     (iss_dest),
        .iss_lat      (iss_lat),
        .iss_var      (iss_var),
        .var_done     (var_done),
        .var_dest     (var_dest),
        .flush        (flush),
        .stall        (stall),
        .stall_src    (stall_src),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [1:0]  en;
        logic [4:0]  a0, a1;
        logic        iv;
        logic [4:0]  idst;
        logic [2:0]  ilat;
        logic        ivar;
        logic        vd;
        logic [4:0]  vdst;
        logic        fl;
        logic [1:0]  exp_src;
        logic [31:0] exp_cyc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mkv(logic dv, logic [1:0] en, logic [4:0] a0, logic [4:0] a1,
                                 logic iv, logic [4:0] idst, logic [2:0] ilat, logic ivar,
                                 logic vd, logic [4:0] vdst, logic fl,
                                 logic [1:0] exp_src, logic [31:0] exp_cyc);
        vec_t v;
        v.dv = dv; v.en = en; v.a0 = a0; v.a1 = a1;
        v.iv = iv; v.idst = idst; v.ilat = ilat; v.ivar = ivar;
        v.vd = vd; v.vdst = vdst; v.fl = fl;
        v.exp_src = exp_src; v.exp_cyc = exp_cyc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        ds_valid    = v.dv;
        ds_src_en   = v.en;
        ds_src_addr = {v.a1, v.a0};
        iss_valid   = v.iv;
        iss_dest    = v.idst;
        iss_lat     = v.ilat;
        iss_var     = v.ivar;
        var_done    = v.vd;
        var_dest    = v.vdst;
        flush       = v.fl;
    endtask

    // Apply inputs at the falling edge, check outputs 1ns later; the rising
    // edge that follows commits the cycle.
    task automatic step(input string name, input vec_t v);
        @(negedge clk);
        drive(v);
        #1;
        chk({name, ".stall_src"}, 32'(stall_src), 32'(v.exp_src));
        chk({name, ".stall"}, 32'(stall), 32'(|v.exp_src));
        chk({name, ".stall_cycles"}, stall_cycles, v.exp_cyc);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drive(mkv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        drive(mkv(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        #1;
        chk("reset.stall", 32'(stall), 32'd0);
        chk("reset.stall_src", 32'(stall_src), 32'd0);
        chk("reset.stall_cycles", stall_cycles, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // dv en a0 a1 | iv idst ilat ivar | vd vdst | fl | exp_src exp_cyc
        // load-use
        vq.push_back(mkv(0, 2'b00, 0, 0,  1, 5, 1, 0,  0, 0, 0, 2'b00, 0));
        vq.push_back(mkv(1, 2'b01, 5, 0,  0, 0, 0, 0,  0, 0, 0, 2'b01, 0));
        vq.push_back(mkv(1, 2'b01, 5, 0,  0, 0, 0, 0,  0, 0, 0, 2'b00, 1));
        // r0 never hazards
        vq.push_back(mkv(1, 2'b11, 0, 0,  1, 0, 3, 0,  0, 0, 0, 2'b00, 1));
        vq.push_back(mkv(1, 2'b11, 0, 0,  0, 0, 0, 0,  0, 0, 0, 2'b00, 1));
        // multiply on source 1: three stall cycles
        vq.push_back(mkv(0, 2'b00, 0, 0,  1, 7, 3, 0,  0, 0, 0, 2'b00, 1));
        vq.push_back(mkv(1, 2'b10, 0, 7,  0, 0, 0, 0,  0, 0, 0, 2'b10, 1));
        vq.push_back(mkv(1, 2'b10, 0, 7,  0, 0, 0, 0,  0, 0, 0, 2'b10, 2));
        vq.push_back(mkv(1, 2'b10, 0, 7,  0, 0, 0, 0,  0, 0, 0, 2'b10, 3));
        vq.push_back(mkv(1, 2'b10, 0, 7,  0, 0, 0, 0,  0, 0, 0, 2'b00, 4));
        // same-cycle issue/flush must not reach stall combinationally
        vq.push_back(mkv(1, 2'b01, 8, 0,  1, 8, 5, 0,  0, 0, 0, 2'b00, 4));
        vq.push_back(mkv(1, 2'b01, 8, 0,  0, 0, 0, 0,  0, 0, 0, 2'b01, 4));
        vq.push_back(mkv(1, 2'b01, 8, 0,  0, 0, 0, 0,  0, 0, 1, 2'b01, 5));
        vq.push_back(mkv(1, 2'b01, 8, 0,  0, 0, 0, 0,  0, 0, 0, 2'b00, 6));
        // ds_valid and per-source enable gating
        vq.push_back(mkv(0, 2'b00, 0, 0,  1, 2, 3, 0,  0, 0, 0, 2'b00, 6));
        vq.push_back(mkv(0, 2'b01, 2, 0,  0, 0, 0, 0,  0, 0, 0, 2'b00, 6));
        vq.push_back(mkv(1, 2'b00, 2, 2,  0, 0, 0, 0,  0, 0, 0, 2'b00, 6));
        vq.push_back(mkv(1, 2'b01, 2, 0,  0, 0, 0, 0,  0, 0, 0, 2'b01, 6));
        vq.push_back(mkv(1, 2'b01, 2, 0,  0, 0, 0, 0,  0, 0, 0, 2'b00, 7));
        // both sources on one pending register
        vq.push_back(mkv(0, 2'b00, 0, 0,  1, 10, 2, 0, 0, 0, 0, 2'b00, 7));
        vq.push_back(mkv(1, 2'b11, 10, 10, 0, 0, 0, 0, 0, 0, 0, 2'b11, 7));
        vq.push_back(mkv(1, 2'b11, 10, 10, 0, 0, 0, 0, 0, 0, 0, 2'b11, 8));
        vq.push_back(mkv(1, 2'b11, 10, 10, 0, 0, 0, 0, 0, 0, 0, 2'b00, 9));

        foreach (vq[k]) step($sformatf("vec%0d", k), vq[k]);

        // divider: busy for 20 cycles, var_done in the 20th releases next cycle
        do_reset();
        step("div.iss", mkv(0, 2'b00, 0, 0, 1, 9, 0, 1, 0, 0, 0, 2'b00, 0));
        for (int c = 0; c < 19; c++)
            step($sformatf("div.hold%0d", c), mkv(1, 2'b01, 9, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 32'(c)));
        step("div.done", mkv(1, 2'b01, 9, 0, 0, 0, 0, 0, 1, 9, 0, 2'b01, 19));
        step("div.rel",  mkv(1, 2'b01, 9, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 20));

        // WAW: var_done r4 and new issue r4 lat 1 in the same cycle
        do_reset();
        step("waw.iss",  mkv(0, 2'b00, 0, 0, 1, 4, 0, 1, 0, 0, 0, 2'b00, 0));
        step("waw.both", mkv(1, 2'b01, 4, 0, 1, 4, 1, 0, 1, 4, 0, 2'b01, 0));
        step("waw.cnt",  mkv(1, 2'b01, 4, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 1));
        step("waw.rel",  mkv(1, 2'b01, 4, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2));
        // issue of a new variable producer beats var_done of the old one
        step("waw2.iss",  mkv(0, 2'b00, 0, 0, 1, 6, 0, 1, 0, 0, 0, 2'b00, 2));
        step("waw2.both", mkv(0, 2'b00, 0, 0, 1, 6, 0, 1, 1, 6, 0, 2'b00, 2));
        step("waw2.busy", mkv(0, 2'b10, 0, 6, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2));
        step("waw2.held", mkv(1, 2'b10, 0, 6, 0, 0, 0, 0, 1, 6, 0, 2'b10, 2));
        step("waw2.rel",  mkv(1, 2'b10, 0, 6, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3));

        // flush two cycles into a lat-5 countdown
        do_reset();
        step("fl.iss", mkv(0, 2'b00, 0, 0, 1, 3, 5, 0, 0, 0, 0, 2'b00, 0));
        step("fl.s1",  mkv(1, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0));
        step("fl.s2",  mkv(1, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0, 1, 2'b01, 1));
        step("fl.rel", mkv(1, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2));

        // asynchronous reset mid-countdown
        step("rs.iss", mkv(0, 2'b00, 0, 0, 1, 3, 5, 0, 0, 0, 0, 2'b00, 2));
        step("rs.s1",  mkv(1, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 2));
        step("rs.s2",  mkv(1, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 3));
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("rs.async.stall", 32'(stall), 32'd0);
        chk("rs.async.stall_src", 32'(stall_src), 32'd0);
        chk("rs.async.stall_cycles", stall_cycles, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step("rs.after", mkv(1, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));
        step("rs.after2", mkv(1, 2'b01, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
